// File: rtl/store_data_align.sv
// store_data_align: turns store requests into word-aligned write beats, splitting lane-crossing stores in two.
// Define STORE_MISALIGN_TRAP_EN to reject crossing stores with err instead of splitting them.
module store_data_align #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        funct3,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;
  state_t state;
  logic [1:0] off;
  logic [3:0] mask;
  logic [7:0] be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic split, bad;
  logic [ADDR_W-1:0] base;
  // Shifting into a double-width field yields both beats at once: the upper half is beat two.
  always_comb begin
    off = req_addr[1:0];
    mask = funct3 == 3'b000 ? 4'b0001 : funct3 == 3'b001 ? 4'b0011 : 4'b1111;
    be_wide = {4'b0000, mask} << off;
    wd_wide = {{DATA_W{1'b0}}, req_data} << {off, 3'b000};
    base = {req_addr[ADDR_W-1:2], 2'b00};
    split = |be_wide[7:4];
`ifdef STORE_MISALIGN_TRAP_EN
    bad = funct3 > 3'b010 || split;
`else
    bad = funct3 > 3'b010;
`endif
  end
`ifndef STORE_MISALIGN_TRAP_EN
  logic split_q;
  logic [ADDR_W-1:0] hi_addr;
  logic [DATA_W-1:0] hi_wdata;
  logic [3:0] hi_be;
  always_ff @(posedge clk) begin
    if (reset) begin
      split_q <= 1'b0;
      hi_addr <= '0;
      hi_wdata <= '0;
      hi_be <= '0;
    end else if (state == IDLE && req_valid && req_ready) begin
      split_q <= split;
      hi_addr <= base + ADDR_W'(4);
      hi_wdata <= wd_wide[2*DATA_W-1:DATA_W];
      hi_be <= be_wide[7:4];
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      mem_wr_en <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          if (bad) err <= 1'b1;
          else begin
            state <= BEAT1;
            req_ready <= 1'b0;
            mem_wr_en <= 1'b1;
            mem_addr <= base;
            mem_wdata <= wd_wide[DATA_W-1:0];
            mem_be <= be_wide[3:0];
          end
        end
        BEAT1: if (mem_ack) begin
`ifndef STORE_MISALIGN_TRAP_EN
          if (split_q) begin
            state <= BEAT2;
            mem_addr <= hi_addr;
            mem_wdata <= hi_wdata;
            mem_be <= hi_be;
          end else begin
            state <= IDLE;
            req_ready <= 1'b1;
            mem_wr_en <= 1'b0;
            done <= 1'b1;
          end
`else
          state <= IDLE;
          req_ready <= 1'b1;
          mem_wr_en <= 1'b0;
          done <= 1'b1;
`endif
        end
`ifndef STORE_MISALIGN_TRAP_EN
        BEAT2: if (mem_ack) begin
          state <= IDLE;
          req_ready <= 1'b1;
          mem_wr_en <= 1'b0;
          done <= 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_store_data_align.sv
// tb_store_data_align: directed-vector bench for store_data_align (both STORE_MISALIGN_TRAP_EN builds).
module tb_store_data_align;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0] funct3 = '0;
  logic mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_be;
  logic mem_ack = 1'b0;
  logic done;
  logic err;
  int tests = 0;
  int fails = 0;
  store_data_align dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .funct3(funct3),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    funct3 = f;
    cyc();
    req_valid = 1'b0;
  endtask
  task automatic ack();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    tests++;
    if ({req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be, done, err} !== {1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: ready=%b wr=%b addr=%h wdata=%h be=%b done=%b err=%b", req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be, done, err);
    end
  endtask
  task automatic test_sw();
    accept(32'h100, 32'hDEADBEEF, 3'b010);
    tests++;
    if ({req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be, done} !== {1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0}) begin
      fails++;
      $display("FAIL sw_beat: ready=%b wr=%b addr=%h wdata=%h be=%b done=%b expected 0 1 00000100 deadbeef 1111 0", req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be, done);
    end
    ack();
    tests++;
    if ({done, req_ready, mem_wr_en} !== 3'b110) begin
      fails++;
      $display("FAIL sw_done: done=%b ready=%b wr=%b expected 1 1 0", done, req_ready, mem_wr_en);
    end
    cyc();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL sw_done_pulse: done=%b expected 0", done);
    end
  endtask
  task automatic test_sb();
    accept(32'h203, 32'h000000A5, 3'b000);
    tests++;
    if ({mem_wr_en, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h200, 32'hA5000000, 4'b1000}) begin
      fails++;
      $display("FAIL sb_beat: wr=%b addr=%h wdata=%h be=%b expected 1 00000200 a5000000 1000", mem_wr_en, mem_addr, mem_wdata, mem_be);
    end
    ack();
    tests++;
    if ({done, mem_wr_en} !== 2'b10) begin
      fails++;
      $display("FAIL sb_done: done=%b wr=%b expected 1 0", done, mem_wr_en);
    end
  endtask
  task automatic test_split(input string name, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                            input logic [68:0] b1, input logic [68:0] b2);
    accept(a, d, f);
`ifdef STORE_MISALIGN_TRAP_EN
    tests++;
    if ({err, mem_wr_en, req_ready} !== 3'b101) begin
      fails++;
      $display("FAIL %s_trap: err=%b wr=%b ready=%b expected 1 0 1", name, err, mem_wr_en, req_ready);
    end
    cyc();
`else
    tests++;
    if ({mem_wr_en, mem_addr, mem_wdata, mem_be} !== b1) begin
      fails++;
      $display("FAIL %s_beat1: got %h expected %h", name, {mem_wr_en, mem_addr, mem_wdata, mem_be}, b1);
    end
    ack();
    tests++;
    if ({mem_wr_en, mem_addr, mem_wdata, mem_be, done} !== {b2, 1'b0}) begin
      fails++;
      $display("FAIL %s_beat2: got %h done=%b expected %h done=0", name, {mem_wr_en, mem_addr, mem_wdata, mem_be}, done, b2);
    end
    ack();
    tests++;
    if ({done, mem_wr_en, req_ready} !== 3'b101) begin
      fails++;
      $display("FAIL %s_done: done=%b wr=%b ready=%b expected 1 0 1", name, done, mem_wr_en, req_ready);
    end
`endif
  endtask
  task automatic test_wait();
    logic [68:0] b;
    accept(32'h40, 32'hCAFEF00D, 3'b010);
    b = {mem_wr_en, mem_addr, mem_wdata, mem_be};
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if ({mem_wr_en, mem_addr, mem_wdata, mem_be, done} !== {1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 1'b0} || {mem_wr_en, mem_addr, mem_wdata, mem_be} !== b) begin
        fails++;
        $display("FAIL wait_hold%0d: wr=%b addr=%h wdata=%h be=%b done=%b", i, mem_wr_en, mem_addr, mem_wdata, mem_be, done);
      end
    end
    ack();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: done=%b expected 1", done);
    end
  endtask
  task automatic test_reset_mid();
    accept(32'h303, 32'h00001234, 3'b001);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests++;
    if ({mem_wr_en, req_ready, done} !== 3'b010) begin
      fails++;
      $display("FAIL reset_mid: wr=%b ready=%b done=%b expected 0 1 0", mem_wr_en, req_ready, done);
    end
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if ({mem_wr_en, done, req_ready} !== 3'b001) begin
        fails++;
        $display("FAIL reset_mid_idle%0d: wr=%b done=%b ready=%b expected 0 0 1", i, mem_wr_en, done, req_ready);
      end
    end
    mem_ack = 1'b0;
  endtask
  task automatic test_invalid();
    accept(32'h100, 32'h55555555, 3'b011);
    tests++;
    if ({err, mem_wr_en, req_ready, done} !== 4'b1010) begin
      fails++;
      $display("FAIL invalid_err: err=%b wr=%b ready=%b done=%b expected 1 0 1 0", err, mem_wr_en, req_ready, done);
    end
    cyc();
    tests++;
    if ({err, mem_wr_en} !== 2'b00) begin
      fails++;
      $display("FAIL invalid_after: err=%b wr=%b expected 0 0", err, mem_wr_en);
    end
  endtask
  task automatic test_back_to_back();
    accept(32'h10, 32'h00000000, 3'b000);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({mem_wr_en, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h10, 32'(i * 32'h11) << (8 * i), 4'(1 << i)}) begin
        fails++;
        $display("FAIL b2b_beat%0d: wr=%b addr=%h wdata=%h be=%b", i, mem_wr_en, mem_addr, mem_wdata, mem_be);
      end
      ack();
      tests++;
      if ({done, req_ready} !== 2'b11) begin
        fails++;
        $display("FAIL b2b_done%0d: done=%b ready=%b expected 1 1", i, done, req_ready);
      end
      if (i < 3) accept(32'h10 + 32'(i + 1), 32'((i + 1) * 32'h11), 3'b000);
    end
  endtask
  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_split("sh303", 32'h303, 32'h00001234, 3'b001,
               {1'b1, 32'h300, 32'h34000000, 4'b1000}, {1'b1, 32'h304, 32'h00000012, 4'b0001});
    test_split("swwrap", 32'hFFFFFFFE, 32'h11223344, 3'b010,
               {1'b1, 32'hFFFFFFFC, 32'h33440000, 4'b1100}, {1'b1, 32'h0, 32'h00001122, 4'b0011});
    test_split("sw101", 32'h101, 32'hA1B2C3D4, 3'b010,
               {1'b1, 32'h100, 32'hB2C3D400, 4'b1110}, {1'b1, 32'h104, 32'h000000A1, 4'b0001});
    test_wait();
    test_reset_mid();
    test_invalid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
